// File: rtl/input_checker.sv
// rtl/input_checker.sv - memory-game player input checker
// Optional no-press timeout is built when INPUT_CHECKER_TIMEOUT_EN is defined.
module input_checker #(
  parameter int SEQ_LEN       = 16,
  parameter int TICK_DIV      = 5000000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start_round,
  input  logic [$clog2(SEQ_LEN):0]   round_len,
  input  logic [3:0]                 buttons,
  input  logic [1:0]                 expected_note,
  output logic [$clog2(SEQ_LEN)-1:0] read_index,
  output logic                       busy,
  output logic                       wrong,
  output logic                       round_done,
  output logic                       timeout
);

  localparam int IW = $clog2(SEQ_LEN);
  localparam int LW = IW + 1;

  typedef enum logic [1:0] {IDLE, LISTEN, RELEASE} state_t;

  state_t        state_q;
  logic          start_q;
  logic [LW-1:0] len_q;
  logic [IW-1:0] read_index_q;
  logic          busy_q, wrong_q, round_done_q, timeout_q;
  logic [3:0]    sync1_q, sync2_q, prev_q;

  logic [LW-1:0] len_d;
  logic [3:0]    press;
  logic          press_any, press_multi, last_note, timeout_hit;
  logic [1:0]    press_note;

  assign len_d       = (round_len > LW'(SEQ_LEN)) ? LW'(SEQ_LEN) : round_len;
  assign press       = sync2_q & ~prev_q;
  assign press_any   = |press;
  assign press_multi = |(press & (press - 4'd1));
  assign last_note   = ({1'b0, read_index_q} == (len_q - LW'(1)));

  always_comb begin
    press_note = 2'd0;
    case (press)
      4'b0010: press_note = 2'd1;
      4'b0100: press_note = 2'd2;
      4'b1000: press_note = 2'd3;
      default: press_note = 2'd0;
    endcase
  end

`ifdef INPUT_CHECKER_TIMEOUT_EN
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [DW-1:0] div_q;
  logic [TW-1:0] ticks_q;
  logic          tick, press_accept, enter_listen;

  assign tick         = busy_q && (div_q == DW'(TICK_DIV - 1));
  assign timeout_hit  = tick && (ticks_q == TW'(TIMEOUT_TICKS - 1));
  assign press_accept = (state_q == LISTEN) && press_any;
  assign enter_listen = (state_q == RELEASE) && (sync2_q == 4'b0);

  // Both counters idle at zero outside a round so every round starts fresh.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      ticks_q <= '0;
    end else if (!busy_q) begin
      div_q   <= '0;
      ticks_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (press_accept || enter_listen)
        ticks_q <= '0;
      else if (tick)
        ticks_q <= ticks_q + TW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{TICK_DIV[0], TIMEOUT_TICKS[0]};
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      len_q        <= '0;
      read_index_q <= '0;
      busy_q       <= 1'b0;
      wrong_q      <= 1'b0;
      round_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
    end else begin
      sync1_q      <= buttons;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      wrong_q      <= 1'b0;
      round_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      start_q      <= start_round && (state_q == IDLE);
      if (start_round && (state_q == IDLE))
        len_q <= len_d;

      case (state_q)
        IDLE: begin
          if (start_q) begin
            read_index_q <= '0;
            if (len_q == '0) begin
              round_done_q <= 1'b1;
            end else begin
              state_q <= LISTEN;
              busy_q  <= 1'b1;
            end
          end
        end
        LISTEN: begin
          // A press in the same cycle as the timeout wins.
          if (press_any) begin
            if (press_multi || (press_note != expected_note)) begin
              wrong_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (last_note) begin
              round_done_q <= 1'b1;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              read_index_q <= read_index_q + IW'(1);
              state_q      <= RELEASE;
            end
          end else if (timeout_hit) begin
            wrong_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        RELEASE: begin
          if (timeout_hit) begin
            wrong_q   <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (sync2_q == 4'b0) begin
            state_q <= LISTEN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_index = read_index_q;
  assign busy       = busy_q;
  assign wrong      = wrong_q;
  assign round_done = round_done_q;
  assign timeout    = timeout_q;

endmodule
